// File: rtl/pipeline_debug_ctrl_pkg.sv
// Shared definitions for the pipeline debug controller: host command codes,
// FSM state encoding and the dump source select.
package pipeline_debug_ctrl_pkg;

  localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_REGS = 8'h52;  // 'R'
  localparam logic [7:0] CMD_INFO = 8'h50;  // 'P'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_LOAD,
    ST_WAIT,
    ST_SEND
  } state_t;

  typedef enum logic {
    SRC_REG,
    SRC_INFO
  } src_t;

endpackage

// File: rtl/pipeline_debug_ctrl_if.sv
// Byte stream valid/ready channel, used for both the command input and the
// transmit output of the debug controller.
interface pipeline_debug_ctrl_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_debug_ctrl_serializer.sv
// Loads one datapath word and streams it out MSB-first as bytes over a
// valid/ready channel; pulses done on the handshake of the final byte.
module dbg_word_serializer #(
  parameter int NB_DATA = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [NB_DATA-1:0]   word,
  output logic                 done,
  pipeline_debug_ctrl_if.master tx
);

  localparam int N_BYTES = NB_DATA / 8;
  localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [NB_DATA-1:0] shreg_reg;
  logic [NB_IDX-1:0]  byte_idx_reg;
  logic               active_reg;
  logic               fire;
  logic               last_byte;

  assign tx.valid  = active_reg;
  assign tx.data   = shreg_reg[NB_DATA-1 -: 8];
  assign fire      = active_reg && tx.ready;
  assign last_byte = (byte_idx_reg == NB_IDX'(N_BYTES - 1));
  assign done      = fire && last_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_reg    <= '0;
      byte_idx_reg <= '0;
      active_reg   <= 1'b0;
    end else if (load) begin
      shreg_reg    <= word;
      byte_idx_reg <= '0;
      active_reg   <= 1'b1;
    end else if (fire) begin
      // Data only moves on a handshake, so tx.data holds while stalled.
      shreg_reg    <= shreg_reg << 8;
      byte_idx_reg <= byte_idx_reg + NB_IDX'(1);
      if (last_byte) begin
        active_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Host debug sequencer: decodes command bytes to run/step the pipeline and
// dumps the register file or PC/cycle-count back as a byte stream.
module pipeline_debug_ctrl
  import pipeline_debug_ctrl_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int N_REGS      = 32,
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_debug_ctrl_if.slave   cmd,
  input  logic                   halt_detected,
  input  logic [NB_DATA-1:0]     cpu_pc,
  output logic                   cpu_enable,
  output logic [NB_REG_ADDR-1:0] dbg_reg_addr,
  input  logic [NB_DATA-1:0]     dbg_reg_data,
  pipeline_debug_ctrl_if.master  tx,
  output logic                   halted,
  output logic                   busy
);

  state_t                 state_reg, state_next;
  src_t                   src_reg, src_next;
  logic [NB_REG_ADDR-1:0] word_idx_reg, word_idx_next;
  logic [NB_REG_ADDR-1:0] last_reg, last_next;
  logic [NB_DATA-1:0]     pc_snap_reg, pc_snap_next;
  logic [NB_DATA-1:0]     cnt_snap_reg, cnt_snap_next;
  logic [NB_DATA-1:0]     cycle_count_reg;
  logic                   halted_reg, halted_next;
  logic                   cmd_fire;
  logic                   ser_load;
  logic                   ser_done;
  logic [NB_DATA-1:0]     ser_word;

  assign cmd.ready    = (state_reg == ST_IDLE);
  assign cmd_fire     = cmd.valid && cmd.ready;
  assign cpu_enable   = (state_reg == ST_RUN) || (state_reg == ST_STEP);
  assign busy         = (state_reg != ST_IDLE);
  assign halted       = halted_reg;
  assign dbg_reg_addr = word_idx_reg;

  // The register file read issued in LOAD is valid during WAIT.
  assign ser_load = (state_reg == ST_WAIT);
  assign ser_word = (src_reg == SRC_REG)      ? dbg_reg_data :
                    (word_idx_reg == '0)      ? pc_snap_reg  : cnt_snap_reg;

  dbg_word_serializer #(
    .NB_DATA (NB_DATA)
  ) u_serializer (
    .clk   (clk),
    .reset (reset),
    .load  (ser_load),
    .word  (ser_word),
    .done  (ser_done),
    .tx    (tx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      src_reg         <= SRC_REG;
      word_idx_reg    <= '0;
      last_reg        <= '0;
      pc_snap_reg     <= '0;
      cnt_snap_reg    <= '0;
      cycle_count_reg <= '0;
      halted_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      src_reg      <= src_next;
      word_idx_reg <= word_idx_next;
      last_reg     <= last_next;
      pc_snap_reg  <= pc_snap_next;
      cnt_snap_reg <= cnt_snap_next;
      halted_reg   <= halted_next;
      if (cpu_enable) begin
        cycle_count_reg <= cycle_count_reg + NB_DATA'(1);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    src_next      = src_reg;
    word_idx_next = word_idx_reg;
    last_next     = last_reg;
    pc_snap_next  = pc_snap_reg;
    cnt_snap_next = cnt_snap_reg;
    halted_next   = halted_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (cmd.data)
            CMD_CONT: if (!halted_reg) state_next = ST_RUN;
            CMD_STEP: if (!halted_reg) state_next = ST_STEP;
            CMD_REGS: begin
              state_next    = ST_LOAD;
              src_next      = SRC_REG;
              word_idx_next = '0;
              last_next     = NB_REG_ADDR'(N_REGS - 1);
            end
            CMD_INFO: begin
              state_next    = ST_LOAD;
              src_next      = SRC_INFO;
              word_idx_next = '0;
              last_next     = NB_REG_ADDR'(1);
              pc_snap_next  = cpu_pc;
              cnt_snap_next = cycle_count_reg;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (halt_detected) begin
          state_next  = ST_IDLE;
          halted_next = 1'b1;
        end
      end
      ST_STEP: begin
        state_next = ST_IDLE;
        if (halt_detected) halted_next = 1'b1;
      end
      ST_LOAD: state_next = ST_WAIT;
      ST_WAIT: state_next = ST_SEND;
      ST_SEND: begin
        if (ser_done) begin
          if (word_idx_reg == last_reg) begin
            state_next = ST_IDLE;
          end else begin
            word_idx_next = word_idx_reg + NB_REG_ADDR'(1);
            state_next    = ST_LOAD;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/pipeline_debug_ctrl.md
# pipeline_debug_ctrl

Debug controller that sequences the pipelined processor under host control. It sits between the UART byte receiver/transmitter and the CPU core inside the top level. Decoded command bytes gate the pipeline's global enable for continuous run or single step. It also serialises the register file, PC and cycle count back to the host as a byte stream.

## Interface
- NB_DATA, 32, datapath word width; must be a multiple of 8
- N_REGS, 32, number of register-file words dumped by 'R'
- NB_REG_ADDR, 5, register-file address width; clog2(N_REGS)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cmd_valid  in  1  receiver has a command byte
- cmd_data  in  8  command byte
- cmd_ready  out  1  controller accepts a byte this cycle
- halt_detected  in  1  HALT instruction has retired in WB
- cpu_pc  in  NB_DATA  current PC from the core
- cpu_enable  out  1  pipeline global enable
- dbg_reg_addr  out  NB_REG_ADDR  register-file debug read address
- dbg_reg_data  in  NB_DATA  register-file read data; registered read, valid one cycle after address
- tx_valid  out  1  byte available for transmitter
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter accepts byte
- halted  out  1  sticky halt flag
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, STEP, LOAD, WAIT, SEND.
- IDLE:
  - cmd_ready=1; a command is accepted on cmd_valid&&cmd_ready.
  - 0x43 'C' -> RUN.
  - 0x53 'S' -> STEP.
  - 0x52 'R' -> LOAD with src=REG, word_idx=0, last=N_REGS-1.
  - 0x50 'P' -> LOAD with src=INFO, word_idx=0, last=1; snapshot cpu_pc and cycle_count at acceptance.
  - Any other byte: consumed, ignored, stay IDLE.
  - While halted=1, 'C' and 'S' are consumed and ignored; 'R' and 'P' still work.
- RUN: cpu_enable=1. If halt_detected=1 -> IDLE and halted<=1.
- STEP: cpu_enable=1 for exactly one cycle -> IDLE. If halt_detected=1 in that cycle, halted<=1.
- cycle_count (NB_DATA bits): +1 on every cycle cpu_enable=1; wraps modulo 2^NB_DATA.
- LOAD: dbg_reg_addr=word_idx -> WAIT.
- WAIT: shift register <= dbg_reg_data (REG), or snapshot PC for word 0 / snapshot count for word 1 (INFO); byte_idx=0 -> SEND.
- SEND:
  - tx_valid=1, tx_data=shreg[NB_DATA-1 -: 8] (MSB first).
  - On tx_ready: shift left 8 and byte_idx+1.
  - After byte NB_DATA/8-1: if word_idx==last -> IDLE, else word_idx+1 -> LOAD.
- cmd_ready=0 in every state except IDLE; bytes from the receiver are held upstream.

## Timing
- Reset values: state=IDLE, cpu_enable=0, tx_valid=0, tx_data=0, dbg_reg_addr=0, halted=0, busy=0, cycle_count=0, cmd_ready=1.
- All outputs are Moore (decoded from registered state); no combinational path from inputs to outputs.
- Command accepted at edge t: cpu_enable=1 from t+1.
- Halt: halt_detected sampled high at edge h -> cpu_enable=0 from h+1. cycle_count includes the halt cycle.
- tx_data is stable while tx_valid&&!tx_ready. tx_valid is never dropped before the handshake, except on reset.
- Minimum latency per word is 2 + NB_DATA/8 cycles with tx_ready held high. An 'R' dump is N_REGS*(2+4) = 192 cycles at defaults.
- halt_detected outside RUN/STEP is ignored.
- Reset mid-dump or mid-run: immediate return to reset values. A partial frame is abandoned.

## Structure
- Shared header debug_defs.vh holds:
  - command codes CMD_CONT, CMD_STEP, CMD_REGS, CMD_INFO;
  - state encodings;
  - source-select encodings SRC_REG, SRC_INFO.
- One sub-module: dbg_word_serializer, covering the load/shift/byte_idx logic and the tx handshake. Its ports are a word load strobe, a done pulse, and the tx interface.
- The FSM, command decode, halted flag and cycle counter stay in pipeline_debug_ctrl.

## Test plan
- Reset then 'S' (0x53) three times, tx_ready=1 -> cpu_enable exactly three single-cycle pulses; a following 'P' returns 8 bytes with cycle bytes 00 00 00 03.
- 'C' with halt_detected raised 20 cycles later -> cpu_enable high 21 cycles then 0; halted=1; a following 'C' is accepted with cpu_enable staying 0.
- Register file preloaded reg[k]=k*0x01010101, send 'R', tx_ready=1 -> 128 bytes, MSB first, ending 1F 1F 1F 1F; busy drops the cycle after the last handshake.
- 'P' with tx_ready toggling 1-0-0-1 -> each byte is held stable until accepted; PC bytes match the value sampled at acceptance even though cpu_pc changes during the send.
- Invalid byte 0x00 then 'X' -> both consumed, cmd_ready stays 1, no tx_valid, no cpu_enable.
- reset asserted during byte 2 of an 'R' dump -> tx_valid=0 immediately (asynchronous); after release, state=IDLE and a new 'R' restarts from reg 0.
